// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package if_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam int unsigned ILEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0;
  localparam int unsigned PC_INC       = 4;

  typedef enum logic {
    START,
    RUN
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN_DEF-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush; head entry is visible combinationally on data_o.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, wr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  // A pop frees the slot in the same cycle, so push into a full FIFO is fine alongside it.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= ptr_inc(wr_q);
      if (do_pop)  rd_q <= ptr_inc(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: pipelined Icache requests, in-order responses buffered for ID,
// with jump redirects that drop responses still in flight.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              ILEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(RESET_PC_DEF),
  parameter int              FETCH_DEPTH = 4,
  parameter int              MAX_OUTST   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fc_stall_i,
  input  logic            fc_jump_flag_i,
  input  logic [XLEN-1:0] fc_jump_pc_i,
  output logic            icache_req_o,
  output logic [XLEN-1:0] icache_addr_o,
  input  logic            icache_gnt_i,
  input  logic            icache_rvalid_i,
  input  logic [ILEN-1:0] icache_rdata_i,
  output logic            id_valid_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [ILEN-1:0] id_inst_o
);

  localparam int OCW = $clog2(MAX_OUTST + 1);
  localparam int BCW = $clog2(FETCH_DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } entry_t;

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [OCW-1:0]  drop_q, drop_d;

  logic [OCW-1:0]  outst;
  logic [BCW-1:0]  occ;
  logic            pend_full, pend_empty, buf_full, buf_empty;
  logic [XLEN-1:0] pend_pc;
  entry_t          buf_wdata, buf_rdata;

  logic run, jump_eff, credit_ok, grant, rsp, buf_push, buf_pop;

  assign run      = (state_q == RUN);
  assign jump_eff = run && fc_jump_flag_i;

  // Counting in-flight requests against free buffer slots guarantees every response lands.
  assign credit_ok = !pend_full && ((32'(outst) + 32'(occ)) < 32'(FETCH_DEPTH));

  assign icache_req_o  = run && !fc_jump_flag_i && credit_ok;
  assign icache_addr_o = pc_q;
  assign grant         = icache_req_o && icache_gnt_i;
  assign rsp           = icache_rvalid_i && !pend_empty;

  assign buf_push  = rsp && !jump_eff && (drop_q == '0);
  assign buf_pop   = !buf_empty && !fc_stall_i && !fc_jump_flag_i;
  assign buf_wdata = '{pc: pend_pc, inst: icache_rdata_i};

  assign id_valid_o = !buf_empty;
  assign id_pc_o    = buf_empty ? '0 : buf_rdata.pc;
  assign id_inst_o  = buf_empty ? '0 : buf_rdata.inst;

  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (jump_eff) begin
      pc_d   = fc_jump_pc_i;
      // Everything still in flight is stale, minus the response consumed right now.
      drop_d = outst - OCW'(rsp);
    end else begin
      if (grant) pc_d = pc_q + XLEN'(PC_INC);
      if (rsp && (drop_q != '0)) drop_d = drop_q - OCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= START;
      pc_q    <= RESET_PC;
      drop_q  <= '0;
    end else begin
      case (state_q)
        START:   state_q <= RUN;
        default: state_q <= RUN;
      endcase
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  fetch_fifo #(
    .WIDTH(XLEN),
    .DEPTH(MAX_OUTST)
  ) u_pend_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush_i(1'b0),
    .push_i (grant),
    .data_i (pc_q),
    .pop_i  (rsp),
    .data_o (pend_pc),
    .full_o (pend_full),
    .empty_o(pend_empty),
    .count_o(outst)
  );

  fetch_fifo #(
    .WIDTH($bits(entry_t)),
    .DEPTH(FETCH_DEPTH)
  ) u_fetch_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush_i(jump_eff),
    .push_i (buf_push),
    .data_i (buf_wdata),
    .pop_i  (buf_pop),
    .data_o (buf_rdata),
    .full_o (buf_full),
    .empty_o(buf_empty),
    .count_o(occ)
  );

  a_rvalid_with_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n) !(icache_rvalid_i && pend_empty));

  a_no_buffer_overflow: assert property (
    @(posedge clk) disable iff (!rst_n) !(buf_push && buf_full && !buf_pop));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: Icache responder plus a queue-based scoreboard
// of the fetch stream, driven by directed phases followed by randomized traffic.
module tb_if_fetch_unit;

  localparam int DEPTH = 4;
  localparam int MOUT  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall, jump, gnt, rvalid;
  logic [31:0] jpc, rdata;
  logic        req, id_valid;
  logic [31:0] addr, id_pc, id_inst;
  logic        req2, v2;
  logic [31:0] addr2, pc2, inst2;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .XLEN(32), .ILEN(32), .RESET_PC(32'h0), .FETCH_DEPTH(DEPTH), .MAX_OUTST(MOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fc_stall_i(stall), .fc_jump_flag_i(jump), .fc_jump_pc_i(jpc),
    .icache_req_o(req), .icache_addr_o(addr), .icache_gnt_i(gnt),
    .icache_rvalid_i(rvalid), .icache_rdata_i(rdata),
    .id_valid_o(id_valid), .id_pc_o(id_pc), .id_inst_o(id_inst)
  );

  if_fetch_unit #(
    .XLEN(32), .ILEN(32), .RESET_PC(32'h8000_0000), .FETCH_DEPTH(DEPTH), .MAX_OUTST(MOUT)
  ) dut2 (
    .clk(clk), .rst_n(rst_n),
    .fc_stall_i(1'b0), .fc_jump_flag_i(1'b0), .fc_jump_pc_i(32'h0),
    .icache_req_o(req2), .icache_addr_o(addr2), .icache_gnt_i(1'b0),
    .icache_rvalid_i(1'b0), .icache_rdata_i(32'h0),
    .id_valid_o(v2), .id_pc_o(pc2), .id_inst_o(inst2)
  );

  typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  req_t        icq[$];
  ent_t        bq[$];
  int          checks, failures, cyc, since_rst, epoch, last_due, lat_lo, lat_hi, delivered;
  logic [31:0] exp_req_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock cycle: present Icache response, check outputs, advance the model.
  task automatic step();
    bit   rsp, jump_eff, grant, deq, req_exp;
    req_t r;
    ent_t e;
    int   due;
    rsp    = (icq.size() > 0) && (icq[0].due <= cyc);
    rvalid = rsp;
    rdata  = rsp ? mem_word(icq[0].addr) : $urandom;
    @(negedge clk);
    jump_eff = jump && (since_rst > 0);
    req_exp  = (since_rst > 0) && !jump && (icq.size() < MOUT) && (icq.size() + bq.size() < DEPTH);
    chk("req", 32'(req), 32'(req_exp));
    if (req) chk("addr", addr, exp_req_pc);
    chk("id_valid", 32'(id_valid), 32'(bq.size() > 0));
    if (id_valid && bq.size() > 0) begin
      chk("id_pc", id_pc, bq[0].pc);
      chk("id_inst", id_inst, bq[0].inst);
    end
    if (since_rst == 0) chk("start_req2", 32'(req2), 32'h0);
    if (since_rst == 1) begin
      chk("reset_pc_req2", 32'(req2), 32'h1);
      chk("reset_pc_addr2", addr2, 32'h8000_0000);
    end
    grant = req && gnt;
    deq   = (bq.size() > 0) && !stall && !jump;
    if (jump_eff) begin
      epoch++;
      exp_req_pc = jpc;
      bq.delete();
    end else if (deq) begin
      delivered++;
      void'(bq.pop_front());
    end
    if (rsp) begin
      r = icq.pop_front();
      if (!jump_eff && r.epoch == epoch) begin
        e.pc   = r.addr;
        e.inst = mem_word(r.addr);
        bq.push_back(e);
      end
    end
    if (grant) begin
      due = cyc + $urandom_range(lat_hi, lat_lo);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      r.addr  = exp_req_pc;
      r.epoch = epoch;
      r.due   = due;
      icq.push_back(r);
      exp_req_pc = exp_req_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
    since_rst++;
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; since_rst = 0; epoch = 0;
    last_due = -1; delivered = 0; lat_lo = 1; lat_hi = 1;
    exp_req_pc = 32'h0;
    stall = 1'b0; jump = 1'b0; jpc = 32'h0; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_id_valid", 32'(id_valid), 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_inst", id_inst, 32'h0);
    chk("rst_req2", 32'(req2), 32'h0);
    chk("rst_v2", 32'(v2), 32'h0);
    chk("rst_pc2", pc2 | inst2, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // START cycle: a jump here must be ignored
    gnt = 1'b1; jump = 1'b1; jpc = 32'h500;
    step();
    jump = 1'b0;

    // Sequential fetch with 1-cycle responses
    repeat (12) step();

    // Stall fills the buffer, then drains in order
    stall = 1'b1;
    repeat (10) step();
    stall = 1'b0;
    repeat (10) step();

    // Grant withheld: address must hold
    gnt = 1'b0;
    repeat (3) step();
    gnt = 1'b1;
    repeat (4) step();

    // Jump with requests in flight
    lat_lo = 3; lat_hi = 3;
    repeat (6) step();
    jump = 1'b1; jpc = 32'h100;
    step();
    jump = 1'b0;
    repeat (10) step();

    // Address wrap at the top of the space
    lat_lo = 1; lat_hi = 1;
    jump = 1'b1; jpc = 32'hFFFF_FFF8;
    step();
    jump = 1'b0;
    repeat (10) step();

    // Randomized traffic
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(3, 0) == 0);
      gnt   = ($urandom_range(3, 0) != 0);
      jump  = ($urandom_range(31, 0) == 0);
      jpc   = $urandom;
      jpc[1:0] = 2'b00;
      step();
    end
    jump = 1'b0;

    chk("progress", 32'(delivered > 300), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Parametrised next-generation instruction-fetch stage.
- Generates sequential or jump PCs and issues pipelined requests to the Icache over a req/gnt address channel, with rvalid/rdata responses.
- Tracks up to MAX_OUTST in-flight requests.
- Buffers returned instructions with their PCs in a FETCH_DEPTH-entry buffer that feeds the IF/ID register, so Icache latency is decoupled from decode stalls.
- Sits between the flow controller (fc), the Icache and the ID stage.

Parameters:
XLEN, 32, address/PC width.
ILEN, 32, instruction width.
RESET_PC, 32'h0, first fetch address after reset.
FETCH_DEPTH, 4, fetch buffer entries; power of 2, at least 2.
MAX_OUTST, 2, maximum granted-but-unanswered requests; at least 1, at most FETCH_DEPTH.

Ports:
clk  in  1  clock
rst_n  in  1  reset
fc_stall_i  in  1  ID cannot accept an instruction this cycle
fc_jump_flag_i  in  1  redirect fetch; flush buffer and in-flight responses
fc_jump_pc_i  in  XLEN  redirect target
icache_req_o  out  1  fetch request valid
icache_addr_o  out  XLEN  fetch address
icache_gnt_i  in  1  request accepted (meaningful only when icache_req_o=1)
icache_rvalid_i  in  1  response valid; responses return in order
icache_rdata_i  in  ILEN  response instruction
id_valid_o  out  1  buffer head valid
id_pc_o  out  XLEN  PC of head instruction
id_inst_o  out  ILEN  head instruction

Behaviour:
- Reset: rst_n is asynchronous, active-low; clk is the clock.
  - Reset values: pc_q=RESET_PC, state=START, outstanding=0, drop_cnt=0, buffer empty.
  - Output reset values: icache_req_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=0.
- States:
  - START: held for exactly 1 cycle after reset release, with no request; then RUN.
  - RUN: normal operation, no other states.
  - Reset asserted mid-operation aborts everything; responses arriving after reset release with outstanding=0 are ignored.
- Request issue, RUN only:
  - icache_req_o = !fc_jump_flag_i && outstanding<MAX_OUTST && (outstanding+occupancy)<FETCH_DEPTH.
  - The credit rule guarantees every response has a buffer slot.
  - icache_addr_o = pc_q.
  - Address is stable while req is held without gnt, unless a jump occurs.
- Grant (req&gnt):
  - pc_q <= pc_q+4, wrapping modulo 2^XLEN.
  - pc_q is pushed into the pending-PC FIFO.
  - outstanding increments.
- Response (rvalid):
  - Pop the pending-PC FIFO; outstanding decrements.
  - If drop_cnt>0: discard the response and decrement drop_cnt.
  - Otherwise: push {pc, rdata} into the fetch buffer.
- Dequeue: when id_valid_o && !fc_stall_i && !fc_jump_flag_i, pop the buffer head. id outputs are driven directly from the head entry, so latency from a response to id_valid_o is 1 cycle.
- Jump, highest priority:
  - pc_q <= fc_jump_pc_i.
  - Buffer cleared.
  - icache_req_o forced 0 in the jump cycle.
  - drop_cnt <= outstanding − (rvalid this cycle ? 1 : 0); a response arriving in the jump cycle is itself dropped.
  - A jump in START is ignored; START always fetches RESET_PC.
- Stall: the buffer holds and fetching continues until credits are exhausted; then icache_req_o=0.
- Simultaneous grant+response: outstanding unchanged; both FIFO ops occur.
- Simultaneous push and pop on a full or empty buffer is legal.
- rvalid with outstanding=0 is a protocol error: ignored in RTL, flagged by a simulation assertion.
- New requests after a jump may issue while drop_cnt>0; ordering guarantees only old responses are dropped.

Decomposition:
- Package if_pkg: default RESET_PC, ILEN, PC increment constant (4), state enum {START, RUN}, fetch-entry struct {pc, inst}.
- Sub-module fetch_fifo: generic synchronous FIFO (WIDTH, DEPTH, push/pop/full/empty/count) with asynchronous active-low reset.
- fetch_fifo is instantiated twice: the pending-PC FIFO (depth MAX_OUTST) and the fetch buffer (depth FETCH_DEPTH).

Test Plan:
- Reset release, gnt tied 1, rvalid 1 cycle after each grant -> req low for 1 cycle; addresses 0x0, 0x4, 0x8, …; id_pc_o sequence 0x0, 0x4, 0x8 with matching rdata.
- fc_stall_i held high, gnt=1, 1-cycle response -> 4 instructions buffered (0x0–0xC); req drops to 0; after release, in-order dequeue at one per cycle and fetching resumes at 0x10.
- 2 requests outstanding (0x8, 0xC), jump to 0x100 -> both later responses dropped; buffer empty; next id_pc_o=0x100.
- Jump in the same cycle as the response for 0x8, 1 other request outstanding -> 0x8 response not buffered; drop_cnt=1; next delivered PC=0x100.
- gnt withheld 3 cycles -> icache_addr_o held at the same PC; pc_q does not advance until gnt.
- pc_q=0xFFFFFFFC granted -> next address 0x0; with RESET_PC=0x8000_0000, first request addresses 0x8000_0000.
